// File: rtl/ltc2333_pkg.sv
// ltc2333_pkg: shared FSM states, control-word layout and SoftSpan codes for the LTC2333 initiator.
package ltc2333_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CNV_HI = 2'd1;
    localparam logic [1:0] ST_CONV   = 2'd2;
    localparam logic [1:0] ST_SHIFT  = 2'd3;
    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_CNV_HI = ST_CNV_HI,
        S_CONV   = ST_CONV,
        S_SHIFT  = ST_SHIFT
    } state_e;
    localparam int CW_V_BIT    = 7;
    localparam int CW_CHAN_LSB = 3;
    localparam int CW_SPAN_LSB = 0;
    localparam int BITS_PER_RESULT_SCK = 12;
    typedef enum logic [2:0] {
        SPAN_0_5V     = 3'b000,
        SPAN_0_5V12   = 3'b001,
        SPAN_PM5V     = 3'b010,
        SPAN_PM5V12   = 3'b011,
        SPAN_0_10V    = 3'b100,
        SPAN_0_10V24  = 3'b101,
        SPAN_PM10V    = 3'b110,
        SPAN_PM10V24  = 3'b111
    } span_e;
    function automatic logic [7:0] ctrl_word(input logic [2:0] chan, input span_e span);
        logic [7:0] w;
        w = '0;
        w[CW_V_BIT] = 1'b1;
        w[CW_CHAN_LSB +: 3] = chan;
        w[CW_SPAN_LSB +: 3] = span;
        return w;
    endfunction
endpackage

// File: rtl/ltc2333_sck_gen.sv
// ltc2333_sck_gen: SCKI divider; while i_run is high emits i_edges full periods starting low,
// with strobes that fire on the clk cycle before the corresponding scki edge lands.
module ltc2333_sck_gen
    import ltc2333_pkg::*;
#(
    parameter int SCK_HALF = 2,
    parameter int EW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_run,
    input  logic [EW-1:0] i_edges,
    output logic          o_sck,
    output logic          o_rise,
    output logic          o_fall,
    output logic          o_done
);
    localparam int DW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    logic [DW-1:0] r_div;
    logic [EW-1:0] r_cnt;
    logic          r_sck;
    logic          w_tick;
    assign w_tick = i_run && (r_div == DW'(SCK_HALF - 1));
    assign o_rise = w_tick && !r_sck;
    assign o_fall = w_tick && r_sck;
    assign o_done = o_fall && (r_cnt == i_edges);
    assign o_sck  = r_sck;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (!i_run) begin
            r_div <= '0;
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) r_sck <= ~r_sck;
            if (o_rise) r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ltc2333_ctrl.sv
// ltc2333_ctrl: LTC2333 CNV/SCKI/SDI initiator, single-shot or free-running frames.
// Define LTC2333_BUSY_INPUT_EN to end conversion on the ADC BUSY pin with CONV_WAIT as timeout.
module ltc2333_ctrl
    import ltc2333_pkg::*;
#(
    parameter int CNV_HIGH  = 4,
    parameter int CONV_WAIT = 64,
    parameter int SCK_HALF  = 2,
    parameter int MAX_SEQ   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_enable,
    input  logic                 i_trigger,
    input  logic [31:0]          i_period,
    input  logic [3:0]           i_seq_len,
    input  logic [8*MAX_SEQ-1:0] i_seq_words,
    input  logic                 i_cfg_load,
`ifdef LTC2333_BUSY_INPUT_EN
    input  logic                 i_adc_busy,
    output logic                 o_busy_timeout,
`endif
    output logic                 o_cnv,
    output logic                 o_scki,
    output logic                 o_sdi,
    output logic                 o_busy,
    output logic                 o_cfg_pending,
    output logic                 o_overrun,
    output logic [31:0]          o_frame_cnt
);
    localparam int EW = $clog2(BITS_PER_RESULT_SCK * MAX_SEQ + 1);
    localparam int SW = 8 * MAX_SEQ;
    state_e        r_state;
    logic [31:0]   r_tmr, r_per, r_frame_cnt;
    logic [3:0]    r_len;
    logic [SW-1:0] r_sr, w_ord;
    logic          r_cnv, r_sdi, r_pend, r_load, r_again, r_ovr;
    logic [31:0]   w_pm1;
    logic [3:0]    w_len;
    logic [EW-1:0] w_edges;
    logic          w_exp, w_req, w_busy, w_pend_now, w_tmr_end, w_conv_end;
    logic          w_run, w_rise, w_fall, w_done;
    assign w_pm1      = (i_period == 32'd0) ? 32'd0 : i_period - 32'd1;
    assign w_exp      = i_enable && (r_per >= w_pm1);
    assign w_req      = i_trigger || w_exp;
    assign w_busy     = r_state != S_IDLE;
    assign w_pend_now = r_pend || i_cfg_load;
    assign w_len      = (i_seq_len == 4'd0) ? 4'd1 :
                        (32'(i_seq_len) > MAX_SEQ) ? 4'(MAX_SEQ) : i_seq_len;
    assign w_edges    = EW'(BITS_PER_RESULT_SCK * 32'(r_len));
    assign w_run      = r_state == S_SHIFT;
    assign w_tmr_end  = r_tmr == 32'(CONV_WAIT - 1);
    // Entry 0 goes to the top so one MSB-first shift sends entries in order; unused entries stay zero.
    always_comb begin
        w_ord = '0;
        for (int k = 0; k < MAX_SEQ; k++)
            if (k < 32'(w_len)) w_ord[8*(MAX_SEQ-1-k) +: 8] = i_seq_words[8*k +: 8];
    end
`ifdef LTC2333_BUSY_INPUT_EN
    logic [1:0] r_bsy_s;
    logic       r_tmo;
    logic       w_bsy_exit;
    assign w_bsy_exit     = (r_tmr >= 32'd1) && !r_bsy_s[1];
    assign w_conv_end     = w_bsy_exit || w_tmr_end;
    assign o_busy_timeout = r_tmo;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bsy_s <= 2'b11;
            r_tmo   <= 1'b0;
        end else begin
            r_bsy_s <= {r_bsy_s[0], i_adc_busy};
            if (r_state == S_CONV && w_tmr_end && !w_bsy_exit) r_tmo <= 1'b1;
        end
    end
`else
    assign w_conv_end = w_tmr_end;
`endif
    ltc2333_sck_gen #(.SCK_HALF(SCK_HALF), .EW(EW)) u_sck (
        .clk     (clk),
        .reset   (reset),
        .i_run   (w_run),
        .i_edges (w_edges),
        .o_sck   (o_scki),
        .o_rise  (w_rise),
        .o_fall  (w_fall),
        .o_done  (w_done)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tmr       <= '0;
            r_per       <= '0;
            r_len       <= 4'd1;
            r_sr        <= '0;
            r_cnv       <= 1'b0;
            r_sdi       <= 1'b0;
            r_pend      <= 1'b0;
            r_load      <= 1'b0;
            r_again     <= 1'b0;
            r_ovr       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_per  <= (!i_enable || r_per >= w_pm1) ? 32'd0 : r_per + 32'd1;
            // A load seen after the frame started survives that frame's clear.
            r_pend <= i_cfg_load || (r_pend && !(w_done && r_load && !r_again));
            if (w_req && w_busy) r_ovr <= 1'b1;
            if (i_cfg_load && w_busy) r_again <= 1'b1;
            case (r_state)
                S_IDLE: if (w_req) begin
                    r_state <= S_CNV_HI;
                    r_tmr   <= '0;
                    r_cnv   <= 1'b1;
                    r_len   <= w_len;
                    r_load  <= w_pend_now;
                    r_again <= 1'b0;
                    r_sr    <= w_pend_now ? w_ord : '0;
                end
                S_CNV_HI: begin
                    r_tmr <= r_tmr + 32'd1;
                    if (r_tmr == 32'(CNV_HIGH - 1)) begin
                        r_state <= S_CONV;
                        r_tmr   <= '0;
                        r_cnv   <= 1'b0;
                    end
                end
                S_CONV: begin
                    r_tmr <= r_tmr + 32'd1;
                    if (w_conv_end) begin
                        r_state <= S_SHIFT;
                        r_tmr   <= '0;
                        r_sdi   <= r_sr[SW-1];
                    end
                end
                S_SHIFT: begin
                    if (w_rise) r_sr <= {r_sr[SW-2:0], 1'b0};
                    if (w_done) begin
                        r_state     <= S_IDLE;
                        r_sdi       <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 32'd1;
                    end else if (w_fall) r_sdi <= r_sr[SW-1];
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign o_cnv         = r_cnv;
    assign o_sdi         = r_sdi;
    assign o_busy        = w_busy;
    assign o_cfg_pending = r_pend;
    assign o_overrun     = r_ovr;
    assign o_frame_cnt   = r_frame_cnt;
endmodule

// File: tb/tb_ltc2333_ctrl.sv
// tb_ltc2333_ctrl: directed frames against ltc2333_ctrl with hand-computed timing and SDI patterns.
module tb_ltc2333_ctrl;
    localparam int MS = 8;
    logic clk = 1'b0, reset = 1'b1, enable = 1'b0, trigger = 1'b0, cfg_load = 1'b0;
    logic [31:0] period = '0;
    logic [3:0] seq_len = 4'd1;
    logic [8*MS-1:0] seq_words = '0;
    logic cnv, scki, sdi, busy, cfg_pending, overrun;
    logic [31:0] frame_cnt;
`ifdef LTC2333_BUSY_INPUT_EN
    logic adc_busy = 1'b1;
    logic busy_timeout;
`endif
    int errors = 0, checks = 0, cyc = 0;
    int f_cr, f_hi, f_gap, f_rise, f_len, p_cr;
    logic [95:0] f_bits;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ltc2333_ctrl #(.CNV_HIGH(4), .CONV_WAIT(64), .SCK_HALF(2), .MAX_SEQ(MS)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_enable      (enable),
        .i_trigger     (trigger),
        .i_period      (period),
        .i_seq_len     (seq_len),
        .i_seq_words   (seq_words),
        .i_cfg_load    (cfg_load),
`ifdef LTC2333_BUSY_INPUT_EN
        .i_adc_busy    (adc_busy),
        .o_busy_timeout(busy_timeout),
`endif
        .o_cnv         (cnv),
        .o_scki        (scki),
        .o_sdi         (sdi),
        .o_busy        (busy),
        .o_cfg_pending (cfg_pending),
        .o_overrun     (overrun),
        .o_frame_cnt   (frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_cfg();
        @(negedge clk) cfg_load = 1'b1;
        @(negedge clk) cfg_load = 1'b0;
    endtask

    // Follows one frame from cnv rise to busy fall; clears a pending trigger on its first sample.
    task automatic measure_frame(output int cr, output int hi, output int gap, output int rises,
                                 output int len, output logic [95:0] bits);
        logic pc, ps, st, dn;
        int cf;
        pc = 0; ps = 0; st = 0; dn = 0; cf = 0;
        cr = 0; hi = 0; gap = 0; rises = 0; len = 0; bits = '0;
        for (int n = 0; n < 3000 && !dn; n++) begin
            @(negedge clk);
            trigger = 1'b0;
            if (!st && cnv) begin st = 1; cr = cyc; end
            if (st && pc && !cnv) begin cf = cyc; hi = cyc - cr; end
            if (st && scki && !ps) begin
                rises++;
                bits = {bits[94:0], sdi};
                if (rises == 1) gap = cyc - cf;
            end
            if (st && !busy) begin len = cyc - cr; dn = 1; end
            pc = cnv;
            ps = scki;
        end
        if (!dn) chk("frame_timeout", 32'(dn), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cnv", 32'(cnv), 0);
        chk("rst_scki", 32'(scki), 0);
        chk("rst_sdi", 32'(sdi), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pending", 32'(cfg_pending), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // single-shot, one entry, no configuration shift
        seq_len = 4'd1;
        @(negedge clk) trigger = 1'b1;
        measure_frame(f_cr, f_hi, f_gap, f_rise, f_len, f_bits);
        chk("t1_cnv_high", f_hi, 4);
        chk("t1_first_rise", f_gap, 66);
        chk("t1_rises", f_rise, 12);
        chk("t1_frame_len", f_len, 116);
        chk("t1_sdi_zero", f_bits[31:0], 0);
        chk("t1_frame_cnt", frame_cnt, 1);
        chk("t1_overrun", 32'(overrun), 0);

        // configuration shift of two entries
        seq_len = 4'd2;
        seq_words = 64'h0000_0000_0000_A1C7;
        pulse_cfg();
        chk("t2_pending_set", 32'(cfg_pending), 1);
        @(negedge clk) trigger = 1'b1;
        measure_frame(f_cr, f_hi, f_gap, f_rise, f_len, f_bits);
        chk("t2_rises", f_rise, 24);
        chk("t2_sdi", f_bits[31:0], 32'h00C7_A100);
        chk("t2_pending_clr", 32'(cfg_pending), 0);

        // cfg_load during SHIFT keeps the request for the next frame
        pulse_cfg();
        @(negedge clk) trigger = 1'b1;
        fork
            measure_frame(f_cr, f_hi, f_gap, f_rise, f_len, f_bits);
            begin
                repeat (100) @(negedge clk);
                cfg_load = 1'b1;
                @(negedge clk) cfg_load = 1'b0;
            end
        join
        chk("t2b_sdi", f_bits[31:0], 32'h00C7_A100);
        chk("t2b_pending_kept", 32'(cfg_pending), 1);
        @(negedge clk) trigger = 1'b1;
        measure_frame(f_cr, f_hi, f_gap, f_rise, f_len, f_bits);
        chk("t2c_sdi", f_bits[31:0], 32'h00C7_A100);
        chk("t2c_pending_clr", 32'(cfg_pending), 0);
        chk("t2c_frame_cnt", frame_cnt, 4);

        // seq_len clamping at both limits
        seq_len = 4'd0;
        @(negedge clk) trigger = 1'b1;
        measure_frame(f_cr, f_hi, f_gap, f_rise, f_len, f_bits);
        chk("clamp_low_rises", f_rise, 12);
        seq_len = 4'd15;
        @(negedge clk) trigger = 1'b1;
        measure_frame(f_cr, f_hi, f_gap, f_rise, f_len, f_bits);
        chk("clamp_high_rises", f_rise, 96);
        chk("clamp_high_len", f_len, 452);

        // free-run with a period longer than the 452-cycle frame
        seq_len = 4'd8;
        period = 32'd500;
        @(negedge clk) enable = 1'b1;
        measure_frame(p_cr, f_hi, f_gap, f_rise, f_len, f_bits);
        chk("t3_rises_a", f_rise, 96);
        measure_frame(f_cr, f_hi, f_gap, f_rise, f_len, f_bits);
        chk("t3_rises_b", f_rise, 96);
        chk("t3_period", f_cr - p_cr, 500);
        chk("t3_overrun", 32'(overrun), 0);
        enable = 1'b0;
        repeat (5) @(negedge clk);

        // free-run with a period shorter than the frame: every other expiry is dropped
        period = 32'd300;
        @(negedge clk) enable = 1'b1;
        measure_frame(p_cr, f_hi, f_gap, f_rise, f_len, f_bits);
        chk("t4_rises_a", f_rise, 96);
        chk("t4_overrun", 32'(overrun), 1);
        measure_frame(f_cr, f_hi, f_gap, f_rise, f_len, f_bits);
        chk("t4_rises_b", f_rise, 96);
        chk("t4_interval", f_cr - p_cr, 600);
        enable = 1'b0;
        repeat (5) @(negedge clk);

        // asynchronous reset while scki and sdi are both high
        seq_words = {MS{8'hFF}};
        pulse_cfg();
        @(negedge clk) trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
        for (int n = 0; n < 300 && !(scki && sdi); n++) @(negedge clk);
        chk("t5_pre_scki_sdi", 32'({scki, sdi}), 32'd3);
        #1 reset = 1'b1;
        #1;
        chk("t5_cnv", 32'(cnv), 0);
        chk("t5_scki", 32'(scki), 0);
        chk("t5_sdi", 32'(sdi), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_overrun", 32'(overrun), 0);
        chk("t5_frame_cnt", frame_cnt, 0);
        @(negedge clk) reset = 1'b0;
        seq_len = 4'd1;
        @(negedge clk) trigger = 1'b1;
        measure_frame(f_cr, f_hi, f_gap, f_rise, f_len, f_bits);
        chk("t5_after_rises", f_rise, 12);
        chk("t5_after_cnt", frame_cnt, 1);

`ifdef LTC2333_BUSY_INPUT_EN
        // ADC BUSY released 30 cycles after cnv falls, then stuck high
        adc_busy = 1'b1;
        @(negedge clk) trigger = 1'b1;
        fork
            measure_frame(f_cr, f_hi, f_gap, f_rise, f_len, f_bits);
            begin
                for (int n = 0; n < 100 && !cnv; n++) @(negedge clk);
                for (int n = 0; n < 100 && cnv; n++) @(negedge clk);
                repeat (30) @(negedge clk);
                adc_busy = 1'b0;
            end
        join
        chk("t6_busy_gap", f_gap, 35);
        chk("t6_no_timeout", 32'(busy_timeout), 0);
        adc_busy = 1'b1;
        @(negedge clk) trigger = 1'b1;
        measure_frame(f_cr, f_hi, f_gap, f_rise, f_len, f_bits);
        chk("t6_timeout_gap", f_gap, 66);
        chk("t6_timeout", 32'(busy_timeout), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
